cnn_layer_seq: RTL

CNN_LAYER_SEQ -- requirements
Module: cnn_layer_seq

---
 rtl/cnn_layer_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cnn_layer_seq.sv
// Sequences a multi-layer CNN run over an external conv engine.
// Each layer gets one launch pulse, then a bounded wait for the engine's done
// pulse. The feature-map buffers ping-pong between layers. The classification
// byte of the last layer is latched for display.
//
// Ports:
//   clk_100m     system clock, rising edge
//   rst_btn      synchronous active-high reset
//   start_btn    run request level; a qualified rising edge starts a run
//   eng_done     single-cycle layer-complete pulse from the engine
//   eng_result   classification byte, valid with eng_done on the last layer
//   eng_start    single-cycle layer launch pulse to the engine
//   layer_idx    current layer (0-based), selects weight bank
//   if_rd_sel    feature-map read buffer (0 = if1, 1 = if2)
//   if_wr_sel    feature-map write buffer, always the complement of if_rd_sel
//   busy         run in progress
//   cnn_done     result valid
//   timeout_err  a layer exceeded its cycle budget
//   led_result   last completed classification
module cnn_layer_seq #(
    parameter int unsigned NUM_LAYERS  = 5,
    parameter int unsigned TIMEOUT_CYC = 60000
) (
    input  logic       clk_100m,
    input  logic       rst_btn,
    input  logic       start_btn,
    input  logic       eng_done,
    input  logic [7:0] eng_result,
    output logic       eng_start,
    output logic [2:0] layer_idx,
    output logic       if_rd_sel,
    output logic       if_wr_sel,
    output logic       busy,
    output logic       cnn_done,
    output logic       timeout_err,
    output logic [7:0] led_result
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       LAYER_LAST = 3'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        NEXT   = 3'd3,
        FINISH = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             start_q;
    // Set once start_btn has been seen low after reset, so a button already
    // held high through reset cannot masquerade as a fresh edge.
    logic             start_arm;
    logic             start_edge;

    assign start_edge = start_btn & ~start_q & start_arm;

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_100m) begin
        if (rst_btn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            start_q     <= 1'b0;
            start_arm   <= 1'b0;
            eng_start   <= 1'b0;
            layer_idx   <= 3'd0;
            if_rd_sel   <= 1'b0;
            if_wr_sel   <= 1'b1;
            busy        <= 1'b0;
            cnn_done    <= 1'b0;
            timeout_err <= 1'b0;
            led_result  <= 8'd0;
        end else begin
            start_q   <= start_btn;
            eng_start <= 1'b0;
            if (!start_btn) begin
                start_arm <= 1'b1;
            end

            case (state)
                IDLE, FINISH, ERROR: begin
                    if (start_edge) begin
                        state       <= LAUNCH;
                        layer_idx   <= 3'd0;
                        if_rd_sel   <= 1'b0;
                        if_wr_sel   <= 1'b1;
                        cnn_done    <= 1'b0;
                        timeout_err <= 1'b0;
                        eng_start   <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                LAUNCH: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end

                // Done wins over timeout when both land on the terminal cycle.
                WAIT: begin
                    if (eng_done) begin
                        if (layer_idx == LAYER_LAST) begin
                            state      <= FINISH;
                            led_result <= eng_result;
                            cnn_done   <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state <= NEXT;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        state       <= ERROR;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                // Advance layer and swap ping-pong buffers before relaunch.
                NEXT: begin
                    state     <= LAUNCH;
                    layer_idx <= layer_idx + 3'd1;
                    if_rd_sel <= ~if_rd_sel;
                    if_wr_sel <= if_rd_sel;
                    eng_start <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
